// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, redirect flush,
// EX operand forwarding and saturating hazard counters.
module id_ex_hazard_ctrl #(
  parameter int REG_ADDR_W         = 3,
  parameter int FLUSH_CYCLES       = 1,
  parameter int STACK_FLUSH_CYCLES = 2,
  parameter int CNT_W              = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_rf_write_en,
  input  logic                  ex_redirect,
  input  logic                  ex_redirect_stack,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_rf_write_en,
  input  logic                  wb_rf_write_en,
  input  logic                  clr_cnt,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int MAXF = (STACK_FLUSH_CYCLES > FLUSH_CYCLES) ?
                        STACK_FLUSH_CYCLES : FLUSH_CYCLES;
  localparam int FL_W = (MAXF < 1) ? 1 : $clog2(MAXF + 1);

  localparam logic [FL_W-1:0] C_FL  = FL_W'(FLUSH_CYCLES);
  localparam logic [FL_W-1:0] C_SFL = FL_W'(STACK_FLUSH_CYCLES);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] FLUSH      = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic [1:0]       r_state;
  logic [FL_W-1:0]  r_left;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0]      w_state_nx;
  logic [FL_W-1:0] w_left_nx;
  logic            w_redir;
  logic            w_match;
  logic            w_load_use;
  logic [FL_W-1:0] w_load_cnt;

  assign w_redir = ex_redirect | ex_redirect_stack;

  assign w_match = (ex_rd == id_rs1) |
                   (id_rs2_used & (ex_rd == id_rs2));

  assign w_load_use = (r_state == RUN) & ~w_redir &
                      id_valid & ex_mem_read &
                      ex_rf_write_en & w_match;

  assign w_load_cnt = ex_redirect_stack ? C_SFL : C_FL;

  assign stall_pc     = w_load_use;
  assign stall_if_id  = w_load_use;
  assign flush_if_id  = w_redir | (r_state == FLUSH);
  assign bubble_id_ex = flush_if_id | w_load_use;

  always_comb begin
    w_state_nx = RUN;
    w_left_nx  = '0;
    if (w_redir) begin
      // A zero-length flush needs only the redirect cycle itself
      if (w_load_cnt != '0) begin
        w_state_nx = FLUSH;
        w_left_nx  = w_load_cnt;
      end
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_load_use) w_state_nx = LOAD_STALL;
        end
        LOAD_STALL: w_state_nx = RUN;
        FLUSH: begin
          if (r_left > FL_W'(1)) begin
            w_state_nx = FLUSH;
            w_left_nx  = r_left - FL_W'(1);
          end
        end
        default: w_state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_left  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_left  <= w_left_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_pc && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_if_id && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  always_comb begin
    fwd_a = FWD_RF;
    if (mem_rf_write_en && mem_rd == ex_rs1)
      fwd_a = FWD_MEM;
    else if (wb_rf_write_en && wb_rd == ex_rs1)
      fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (mem_rf_write_en && mem_rd == ex_rs2)
      fwd_b = FWD_MEM;
    else if (wb_rf_write_en && wb_rd == ex_rs2)
      fwd_b = FWD_WB;
  end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Scoreboard bench for id_ex_hazard_ctrl: directed cycles push
// expected outputs, a monitor pops and compares mid-cycle.
module tb_id_ex_hazard_ctrl;

  localparam int AW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs2_used;
  logic [AW-1:0] ex_rd;
  logic          ex_mem_read;
  logic          ex_rf_write_en;
  logic          ex_redirect;
  logic          ex_redirect_stack;
  logic [AW-1:0] ex_rs1;
  logic [AW-1:0] ex_rs2;
  logic [AW-1:0] mem_rd;
  logic [AW-1:0] wb_rd;
  logic          mem_rf_write_en;
  logic          wb_rf_write_en;
  logic          clr_cnt;
  logic          stall_pc;
  logic          stall_if_id;
  logic          flush_if_id;
  logic          bubble_id_ex;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  id_ex_hazard_ctrl #(
    .REG_ADDR_W(AW),
    .CNT_W     (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs2_used      (id_rs2_used),
    .ex_rd            (ex_rd),
    .ex_mem_read      (ex_mem_read),
    .ex_rf_write_en   (ex_rf_write_en),
    .ex_redirect      (ex_redirect),
    .ex_redirect_stack(ex_redirect_stack),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .mem_rd           (mem_rd),
    .wb_rd            (wb_rd),
    .mem_rf_write_en  (mem_rf_write_en),
    .wb_rf_write_en   (wb_rf_write_en),
    .clr_cnt          (clr_cnt),
    .stall_pc         (stall_pc),
    .stall_if_id      (stall_if_id),
    .flush_if_id      (flush_if_id),
    .bubble_id_ex     (bubble_id_ex),
    .fwd_a            (fwd_a),
    .fwd_b            (fwd_b),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    nm;
    bit [3:0] ctl;
    bit [1:0] fa;
    bit [1:0] fb;
    int       sc;
    int       fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // ctl = {stall_pc, stall_if_id, flush_if_id, bubble_id_ex}
  task automatic ex(input string nm, input bit [3:0] ctl,
                    input bit [1:0] fa, input bit [1:0] fb,
                    input int sc, input int fc);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.fa = fa; e.fb = fb;
    e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic zero_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs2_used = 0;
    ex_rd = 0; ex_mem_read = 0; ex_rf_write_en = 0;
    ex_redirect = 0; ex_redirect_stack = 0;
    ex_rs1 = 0; ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
    mem_rf_write_en = 0; wb_rf_write_en = 0; clr_cnt = 0;
  endtask

  task automatic lu(input logic [AW-1:0] r);
    id_valid = 1; ex_mem_read = 1; ex_rf_write_en = 1;
    ex_rd = r; id_rs1 = r;
  endtask

  initial begin : monitor
    exp_t e;
    bit [3:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {stall_pc, stall_if_id, flush_if_id, bubble_id_ex};
        n_cmp++;
        if (act !== e.ctl || fwd_a !== e.fa || fwd_b !== e.fb ||
            int'(stall_cnt) != e.sc || int'(flush_cnt) != e.fc) begin
          n_bad++;
          $display("FAIL %s: got ctl=%b fa=%b fb=%b sc=%0d fc=%0d want ctl=%b fa=%b fb=%b sc=%0d fc=%0d",
                   e.nm, act, fwd_a, fwd_b, stall_cnt, flush_cnt,
                   e.ctl, e.fa, e.fb, e.sc, e.fc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    if (!done) begin
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin : driver
    rst = 1;
    zero_in();
    @(negedge clk); ex("reset", 4'b0000, 0, 0, 0, 0);
    @(negedge clk); rst = 0;
    ex("idle", 4'b0000, 0, 0, 0, 0);

    @(negedge clk); lu(3);
    ex("lu_stall", 4'b1101, 0, 0, 0, 0);
    @(negedge clk);
    ex("lu_hold_off", 4'b0000, 0, 0, 1, 0);
    @(negedge clk); zero_in();
    ex("lu_after", 4'b0000, 0, 0, 1, 0);

    @(negedge clk);
    id_valid = 1; ex_mem_read = 1; ex_rf_write_en = 1;
    ex_rd = 5; id_rs2 = 5; id_rs1 = 2; id_rs2_used = 0;
    ex("rs2_unused", 4'b0000, 0, 0, 1, 0);
    @(negedge clk); id_rs2_used = 1;
    ex("rs2_used", 4'b1101, 0, 0, 1, 0);
    @(negedge clk); zero_in();
    ex("rs2_after", 4'b0000, 0, 0, 2, 0);
    @(negedge clk); clr_cnt = 1;
    ex("clr1", 4'b0000, 0, 0, 2, 0);

    @(negedge clk); clr_cnt = 0; ex_redirect_stack = 1;
    ex("stk_c1", 4'b0011, 0, 0, 0, 0);
    @(negedge clk); ex_redirect_stack = 0; lu(3);
    ex("stk_c2", 4'b0011, 0, 0, 0, 1);
    @(negedge clk);
    ex("stk_c3", 4'b0011, 0, 0, 0, 2);
    @(negedge clk); zero_in();
    ex("stk_end", 4'b0000, 0, 0, 0, 3);

    @(negedge clk); lu(3); ex_redirect = 1;
    ex("prio_c1", 4'b0011, 0, 0, 0, 3);
    @(negedge clk); zero_in();
    ex("prio_flush", 4'b0011, 0, 0, 0, 4);
    @(negedge clk);
    ex("prio_end", 4'b0000, 0, 0, 0, 5);

    @(negedge clk); ex_redirect = 1; ex_redirect_stack = 1;
    ex("both_c1", 4'b0011, 0, 0, 0, 5);
    @(negedge clk); zero_in();
    ex("both_c2", 4'b0011, 0, 0, 0, 6);
    @(negedge clk);
    ex("both_c3", 4'b0011, 0, 0, 0, 7);
    @(negedge clk);
    ex("both_end", 4'b0000, 0, 0, 0, 8);

    @(negedge clk);
    ex_rs1 = 4; mem_rd = 4; wb_rd = 4; ex_rs2 = 6;
    mem_rf_write_en = 1; wb_rf_write_en = 1;
    ex("fwd_mem", 4'b0000, 2'b01, 2'b00, 0, 8);
    @(negedge clk); mem_rf_write_en = 0;
    ex("fwd_wb", 4'b0000, 2'b10, 2'b00, 0, 8);
    @(negedge clk); ex_rs2 = 4; mem_rf_write_en = 1;
    ex("fwd_b_mem", 4'b0000, 2'b01, 2'b01, 0, 8);
    @(negedge clk); zero_in(); wb_rf_write_en = 1;
    ex("fwd_r0", 4'b0000, 2'b10, 2'b10, 0, 8);

    @(negedge clk); zero_in(); clr_cnt = 1;
    ex("clr2", 4'b0000, 0, 0, 0, 8);
    @(negedge clk); clr_cnt = 0; lu(1);
    for (int i = 0; i < 40; i++) begin
      int s;
      s = (i + 1) / 2;
      if (s > 15) s = 15;
      ex("sat_loop", (i % 2 == 0) ? 4'b1101 : 4'b0000, 0, 0, s, 0);
      @(negedge clk);
    end
    clr_cnt = 1;
    ex("sat_clr", 4'b1101, 0, 0, 15, 0);
    @(negedge clk); clr_cnt = 0;
    ex("clr_wins", 4'b0000, 0, 0, 0, 0);

    @(negedge clk); zero_in(); ex_redirect_stack = 1;
    ex("rst_pre", 4'b0011, 0, 0, 0, 0);
    @(negedge clk); ex_redirect_stack = 0;
    ex("rst_mid", 4'b0011, 0, 0, 0, 1);
    @(negedge clk); rst = 1;
    ex("rst_flush", 4'b0000, 0, 0, 0, 0);
    @(negedge clk); rst = 0;
    ex("rst_after", 4'b0000, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
